// File: rtl/instruction_fetch_unit.sv
// RV32 instruction fetch unit: owns the PC, fetches over req/ack, presents to decode over valid/ready.
// Optional saturating performance counters are built when IFU_PERF_CNT_EN is defined.
module instruction_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    input  logic                  branch_taken,
    input  logic [ADDR_W-1:0]     branch_target,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [31:0]           Instruction,
    output logic [6:0]            Opcode,
    output logic [3:0]            Funct,
    output logic [ADDR_W-1:0]     pc_out,
    output logic [PERF_CNT_W-1:0] fetch_count,
    output logic [PERF_CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_VALID
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic                r_squash;
    logic                w_squash_next;
    logic                w_load;
    logic [31:0]         r_instr;
    logic [ADDR_W-1:0]   r_pc_out;
    logic [ADDR_W-1:0]   w_target_aligned;

    assign w_target_aligned = branch_target & ~ADDR_W'(3);

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_squash_next = r_squash;
        w_load        = 1'b0;
        case (r_state)
            S_IDLE: w_state_next = S_REQ;
            S_REQ: begin
                if (branch_taken) begin
                    // An ack this cycle closes the outstanding fetch; otherwise its data is still owed.
                    w_pc_next     = w_target_aligned;
                    w_squash_next = ~imem_ack;
                end else if (imem_ack) begin
                    if (r_squash) begin
                        w_squash_next = 1'b0;
                    end else begin
                        w_load       = 1'b1;
                        w_pc_next    = r_pc + ADDR_W'(4);
                        w_state_next = S_VALID;
                    end
                end
            end
            S_VALID: begin
                if (branch_taken) begin
                    w_pc_next    = w_target_aligned;
                    w_state_next = S_REQ;
                end else if (dec_ready) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_squash <= 1'b0;
            r_instr  <= '0;
            r_pc_out <= '0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_squash <= w_squash_next;
            if (w_load) begin
                r_instr  <= imem_rdata;
                r_pc_out <= r_pc;
            end
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign dec_valid   = (r_state == S_VALID);
    assign Instruction = r_instr;
    assign pc_out      = r_pc_out;
    assign Opcode      = r_instr[6:0];
    assign Funct       = {r_instr[30], r_instr[14:12]};

`ifdef IFU_PERF_CNT_EN
    logic                  w_transfer;
    logic                  w_flush;
    logic [PERF_CNT_W-1:0] r_fetch_count;
    logic [PERF_CNT_W-1:0] r_flush_count;

    // Flushes: a VALID instruction redirected away, or a returned word that is dropped.
    assign w_transfer = (r_state == S_VALID) & dec_ready & ~branch_taken;
    assign w_flush    = ((r_state == S_VALID) & branch_taken)
                      | ((r_state == S_REQ) & imem_ack & (branch_taken | r_squash));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_transfer && !(&r_fetch_count)) r_fetch_count <= r_fetch_count + PERF_CNT_W'(1);
            if (w_flush && !(&r_flush_count))    r_flush_count <= r_flush_count + PERF_CNT_W'(1);
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit: a latching memory model plus an
// instruction-stream reference model that predicts every visible output each cycle.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] Instruction;
    logic [6:0]  Opcode;
    logic [3:0]  Funct;
    logic [31:0] pc_out;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .ADDR_W    (32),
        .RESET_PC  (RESET_PC),
        .PERF_CNT_W(32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .Instruction  (Instruction),
        .Opcode       (Opcode),
        .Funct        (Funct),
        .pc_out       (pc_out),
        .fetch_count  (fetch_count),
        .flush_count  (flush_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction memory contents as a pure function of address (address 0 holds a sub).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h40B50533;
    endfunction

    typedef enum {P_WAIT, P_FETCH, P_PRESENT} phase_t;

    phase_t      m_phase;
    logic [31:0] m_pc;      // address of the next instruction decode should receive
    logic        m_squash;  // a redirect happened while a fetch was in flight
    logic        m_fresh;   // nothing captured since reset
    int unsigned m_fetch;
    int unsigned m_flush;

    logic        mb_busy;
    logic [31:0] mb_addr;
    int          mb_cnt;

    task automatic model_reset();
        m_phase  = P_WAIT;
        m_pc     = RESET_PC;
        m_squash = 1'b0;
        m_fresh  = 1'b1;
        m_fetch  = 0;
        m_flush  = 0;
        mb_busy  = 1'b0;
    endtask

    task automatic compare_outputs();
        logic [31:0] w;
        w = mem_word(m_pc);
        case (m_phase)
            P_WAIT: begin
                check("idle_req", imem_req, 1'b0);
                check("idle_valid", dec_valid, 1'b0);
                check("idle_addr", imem_addr, m_pc);
            end
            P_FETCH: begin
                check("fetch_req", imem_req, 1'b1);
                check("fetch_valid", dec_valid, 1'b0);
                check("fetch_addr", imem_addr, m_pc);
            end
            default: begin
                check("present_req", imem_req, 1'b0);
                check("present_valid", dec_valid, 1'b1);
                check("present_addr", imem_addr, m_pc + 32'd4);
                check("instr", Instruction, w);
                check("pc_out", pc_out, m_pc);
                check("opcode", {25'd0, Opcode}, {25'd0, w[6:0]});
                check("funct", {28'd0, Funct}, {28'd0, w[30], w[14:12]});
            end
        endcase
        if (m_fresh && m_phase != P_PRESENT) begin
            check("reset_instr", Instruction, 32'h0);
            check("reset_pc_out", pc_out, 32'h0);
        end
`ifdef IFU_PERF_CNT_EN
        check("fetch_count", fetch_count, m_fetch);
        check("flush_count", flush_count, m_flush);
`else
        check("fetch_count", fetch_count, 32'h0);
        check("flush_count", flush_count, 32'h0);
`endif
    endtask

    task automatic model_step(input logic br, input logic [31:0] tgt, input logic ack, input logic rdy);
        case (m_phase)
            P_WAIT: m_phase = P_FETCH;
            P_FETCH: begin
                if (br) begin
                    m_pc = tgt & ~32'd3;
                    if (ack) begin
                        m_flush++;
                        m_squash = 1'b0;
                    end else begin
                        m_squash = 1'b1;
                    end
                end else if (ack) begin
                    if (m_squash) begin
                        m_flush++;
                        m_squash = 1'b0;
                    end else begin
                        m_phase = P_PRESENT;
                        m_fresh = 1'b0;
                    end
                end
            end
            default: begin
                if (br) begin
                    m_pc = tgt & ~32'd3;
                    m_flush++;
                    m_phase = P_FETCH;
                end else if (rdy) begin
                    m_fetch++;
                    m_pc    = m_pc + 32'd4;
                    m_phase = P_FETCH;
                end
            end
        endcase
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom % 5)
            0:       return $urandom;
            1:       return 32'h0000_0103;
            2:       return 32'h0000_0080;
            3:       return 32'hFFFF_FFF9;
            default: return 32'hFFFF_FFFE;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int rst_block;
        reset         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        branch_taken  = 1'b0;
        branch_target = '0;
        dec_ready     = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        rst_block = -1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            compare_outputs();

            // Once per 500-cycle block, reset mid-operation: alternately while fetching and while presenting.
            if ((cyc / 500) != rst_block && (cyc % 500) >= 250 &&
                m_phase == (((cyc / 500) % 2 == 1) ? P_PRESENT : P_FETCH)) begin
                rst_block = cyc / 500;
                do_reset();
                continue;
            end

            dec_ready     = ($urandom % 3) != 0;
            branch_taken  = ($urandom % 9) == 0;
            branch_target = pick_target();

            if (imem_req) begin
                if (!mb_busy) begin
                    mb_busy = 1'b1;
                    mb_addr = imem_addr;
                    mb_cnt  = int'($urandom_range(0, 3));
                end
                if (mb_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(mb_addr);
                    mb_busy    = 1'b0;
                end else begin
                    mb_cnt--;
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                end
            end else begin
                imem_ack   = ($urandom % 4) == 0;
                imem_rdata = $urandom;
            end

            model_step(branch_taken, branch_target, imem_ack, dec_ready);
            @(posedge clk);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
